key_repeat_shaper: RTL and testbench
====================================

Name: key_repeat_shaper

Overview:
- Upstream input stage for the falling-block game logic.
- Converts the raw, level-held USB keycode into discrete, rate-controlled move commands: one on press, then delayed auto-shift with auto-repeat for left, right and down.
- Rotate is a one-shot per press.
- Commands are held in a one-entry valid/ack slot that the game logic drains on its move tick, so short taps between ticks are not lost.

Parameters:
DAS_FRAMES, 10, frames from first emission to first auto-repeat (legal 1..63)
ARR_FRAMES, 3, frames between successive auto-repeats (legal 1..63)

Ports:
frame_clk  in  1  frame-rate clock; the only clock
Reset  in  1  synchronous reset, active-high
keycode  in  8  raw keycode from the USB keyboard interface
cmd_ack  in  1  consumer accepts the current command this cycle
cmd_key  out  8  command keycode: 0x04 left, 0x07 right, 0x16 down, 0x1A rotate
cmd_valid  out  1  cmd_key holds an unconsumed command
cmd_drop  out  1  one-cycle pulse: an unconsumed command was overwritten

Behaviour:
- Clocking and reset
  - Single clock frame_clk.
  - Reset is synchronous, active-high, sampled on the rising edge.
  - Reset values: cmd_key=0x00, cmd_valid=0, cmd_drop=0, state=IDLE, held_key=0x00, counter=0.
  - Reset mid-hold discards the pending command and the repeat state. After reset deasserts, a still-held key is treated as a new press.
- Key filtering (combinational): fkey = keycode if keycode is one of {0x04, 0x07, 0x16, 0x1A}, else 0x00. Repeatable = fkey is 0x04, 0x07 or 0x16.
- "Emit k" means: cmd_key<=k, cmd_valid<=1.
- States: IDLE, DELAY, REPEAT, HOLD. Counter is 6 bits and counts down.
- Press, from any state: fkey != 0 and fkey != held_key.
  - held_key<=fkey, emit fkey.
  - Repeatable key: state<=DELAY, counter<=DAS_FRAMES-1.
  - Rotate: state<=HOLD.
  - A different key pressed while one is held is a fresh press and restarts DAS.
- Release, from any state: fkey == 0.
  - state<=IDLE, held_key<=0.
  - A pending command stays valid until acked.
- DELAY, same key held:
  - counter != 0: decrement.
  - counter == 0: emit held_key, state<=REPEAT, counter<=ARR_FRAMES-1.
- REPEAT, same key held: counter != 0 decrements; counter == 0 emits and reloads ARR_FRAMES-1.
- HOLD: no further emissions until release or press.
- Emission timing (press sampled at edge 0):
  - First command visible after edge 0 (1-cycle latency).
  - Repeats after edges DAS_FRAMES, DAS_FRAMES+ARR_FRAMES, DAS_FRAMES+2*ARR_FRAMES, ...
- Handshake:
  - cmd_ack with cmd_valid=1 and no emission on the same edge: cmd_valid<=0, cmd_key<=0x00.
  - cmd_ack and emission on the same edge: new command loads, cmd_valid stays 1, no drop.
  - Emission while cmd_valid=1 and cmd_ack=0: overwrite (latest wins), cmd_drop<=1 for one cycle.
  - cmd_ack while cmd_valid=0 is ignored.
- cmd_drop is 0 on every cycle without an overwrite.

Optional Feature:
Macro: KEY_DROP_COUNT_EN
- Defined:
  - Adds output port drop_count, 8 bits: saturating count of cmd_drop pulses.
  - Sticks at 0xFF; cleared only by Reset.
  - Reset value 0x00.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Tap: keycode=0x04 for 1 cycle, then 0x00, no ack -> cmd_valid=1, cmd_key=0x04 from cycle 1 and held until ack; no repeat; cmd_drop=0.
- Hold right, DAS=10, ARR=3, ack asserted every cycle -> cmd_valid pulses after edges 0, 10, 13, 16, 19, each with cmd_key=0x07; no other pulses.
- Hold 0x1A for 40 cycles with ack every cycle -> exactly one command (0x1A) after edge 0.
- Hold 0x04 with no ack -> cmd_drop pulses after edges 10, 13, 16; cmd_key is always the latest 0x04; with KEY_DROP_COUNT_EN, drop_count=3 after edge 16.
- 0x04 held 5 cycles, then switch to 0x07 -> 0x07 emitted 1 cycle after the switch; the 0x07 auto-repeat occurs 10 cycles after the switch. Ack and emission on the same edge -> cmd_valid stays 1, no drop.
- Reset pulse during REPEAT with the key still held -> all outputs 0 on the reset edge; a new press emission occurs on the first edge after Reset deasserts. Unrecognized keycode 0x2C -> treated as release, no emission.

Source files
------------

// File: rtl/key_repeat_shaper.sv
// Keycode to move-command shaper: press emission, DAS/ARR auto-repeat, one-entry valid/ack slot.
// Optional saturating drop counter output enabled by defining KEY_DROP_COUNT_EN.
module key_repeat_shaper #(
  parameter int DAS_FRAMES = 10,
  parameter int ARR_FRAMES = 3
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       cmd_ack,
  output logic [7:0] cmd_key,
  output logic       cmd_valid,
  output logic       cmd_drop
`ifdef KEY_DROP_COUNT_EN
  ,
  output logic [7:0] drop_count
`endif
);

  localparam logic [7:0] KEY_LEFT   = 8'h04;
  localparam logic [7:0] KEY_RIGHT  = 8'h07;
  localparam logic [7:0] KEY_DOWN   = 8'h16;
  localparam logic [7:0] KEY_ROTATE = 8'h1A;
  localparam logic [5:0] DAS_LOAD   = 6'(DAS_FRAMES - 1);
  localparam logic [5:0] ARR_LOAD   = 6'(ARR_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HOLD} state_t;

  state_t     state;
  logic [7:0] held_key;
  logic [5:0] counter;

  logic [7:0] fkey;
  logic       repeatable;
  logic       press;
  logic       timeout;
  logic       emit;
  logic       overwrite;

  always_comb begin
    fkey = 8'h00;
    if (keycode == KEY_LEFT || keycode == KEY_RIGHT ||
        keycode == KEY_DOWN || keycode == KEY_ROTATE)
      fkey = keycode;
  end

  // Whenever something is emitted the emitted code equals fkey, whether it is a press or a repeat.
  assign repeatable = (fkey == KEY_LEFT) || (fkey == KEY_RIGHT) || (fkey == KEY_DOWN);
  assign press      = (fkey != 8'h00) && (fkey != held_key);
  assign timeout    = (fkey != 8'h00) && !press && (counter == 6'd0) &&
                      (state == DELAY || state == REPEAT);
  assign emit       = press || timeout;
  assign overwrite  = emit && cmd_valid && !cmd_ack;

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state     <= IDLE;
      held_key  <= 8'h00;
      counter   <= 6'd0;
      cmd_key   <= 8'h00;
      cmd_valid <= 1'b0;
      cmd_drop  <= 1'b0;
    end else begin
      if (fkey == 8'h00) begin
        state    <= IDLE;
        held_key <= 8'h00;
      end else if (press) begin
        held_key <= fkey;
        if (repeatable) begin
          state   <= DELAY;
          counter <= DAS_LOAD;
        end else begin
          state <= HOLD;
        end
      end else begin
        case (state)
          DELAY: begin
            if (counter != 6'd0) begin
              counter <= counter - 6'd1;
            end else begin
              state   <= REPEAT;
              counter <= ARR_LOAD;
            end
          end
          REPEAT: begin
            if (counter != 6'd0) counter <= counter - 6'd1;
            else                 counter <= ARR_LOAD;
          end
          default: ;
        endcase
      end

      // An emission always wins the slot; an ack only empties it when nothing new arrives.
      if (emit) begin
        cmd_key   <= fkey;
        cmd_valid <= 1'b1;
        cmd_drop  <= overwrite;
      end else begin
        cmd_drop <= 1'b0;
        if (cmd_ack && cmd_valid) begin
          cmd_valid <= 1'b0;
          cmd_key   <= 8'h00;
        end
      end
    end
  end

`ifdef KEY_DROP_COUNT_EN
  always_ff @(posedge frame_clk) begin
    if (Reset)
      drop_count <= 8'h00;
    else if (overwrite && drop_count != 8'hFF)
      drop_count <= drop_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_key_repeat_shaper.sv
// Directed self-checking bench for key_repeat_shaper (DAS_FRAMES=10, ARR_FRAMES=3).
module tb_key_repeat_shaper;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode;
  logic       cmd_ack;
  logic [7:0] cmd_key;
  logic       cmd_valid;
  logic       cmd_drop;
`ifdef KEY_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif

  int compared;
  int mismatched;

  key_repeat_shaper #(.DAS_FRAMES(10), .ARR_FRAMES(3)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .cmd_ack   (cmd_ack),
    .cmd_key   (cmd_key),
    .cmd_valid (cmd_valid),
    .cmd_drop  (cmd_drop)
`ifdef KEY_DROP_COUNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Drive one cycle of inputs, let the edge happen, then sample 1 time unit later.
  task automatic applyStimulus(input logic [7:0] key, input logic ack);
    keycode = key;
    cmd_ack = ack;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %02h expected %02h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkSlot(input string tag, input logic v, input logic [7:0] k, input logic d);
    checkOutput({tag, "_valid"}, {7'b0, cmd_valid}, {7'b0, v});
    checkOutput({tag, "_key"}, cmd_key, k);
    checkOutput({tag, "_drop"}, {7'b0, cmd_drop}, {7'b0, d});
  endtask

  initial begin
    logic exp_v;
    logic exp_d;
    compared   = 0;
    mismatched = 0;
    Reset   = 1'b1;
    keycode = 8'h00;
    cmd_ack = 1'b0;

    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkSlot("reset", 1'b0, 8'h00, 1'b0);
`ifdef KEY_DROP_COUNT_EN
    checkOutput("reset_drop_count", drop_count, 8'h00);
`endif
    Reset = 1'b0;

    // Tap left, no ack: command held, never repeated
    applyStimulus(8'h04, 1'b0);
    checkSlot("tap_first", 1'b1, 8'h04, 1'b0);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(8'h00, 1'b0);
      checkSlot("tap_held", 1'b1, 8'h04, 1'b0);
    end
    applyStimulus(8'h00, 1'b1);
    checkSlot("tap_acked", 1'b0, 8'h00, 1'b0);
    applyStimulus(8'h00, 1'b1);
    checkSlot("ack_idle_ignored", 1'b0, 8'h00, 1'b0);

    // Hold right with ack every cycle: pulses after edges 0,10,13,16,19
    for (int e = 0; e < 21; e++) begin
      applyStimulus(8'h07, 1'b1);
      exp_v = (e == 0 || e == 10 || e == 13 || e == 16 || e == 19);
      checkSlot("hold_right", exp_v, exp_v ? 8'h07 : 8'h00, 1'b0);
    end
    applyStimulus(8'h00, 1'b1);
    checkSlot("hold_right_release", 1'b0, 8'h00, 1'b0);

    // Rotate held 40 cycles: one-shot
    for (int e = 0; e < 40; e++) begin
      applyStimulus(8'h1A, 1'b1);
      exp_v = (e == 0);
      checkSlot("rotate", exp_v, exp_v ? 8'h1A : 8'h00, 1'b0);
    end
    applyStimulus(8'h00, 1'b1);
    checkSlot("rotate_release", 1'b0, 8'h00, 1'b0);

    // Hold left without ack: overwrites after edges 10,13,16
    for (int e = 0; e < 17; e++) begin
      applyStimulus(8'h04, 1'b0);
      exp_d = (e == 10 || e == 13 || e == 16);
      checkSlot("noack_left", 1'b1, 8'h04, exp_d);
    end
`ifdef KEY_DROP_COUNT_EN
    checkOutput("drop_count_after_16", drop_count, 8'h03);
`endif
    applyStimulus(8'h00, 1'b1);
    checkSlot("noack_release", 1'b0, 8'h00, 1'b0);

    // Left 5 cycles then switch to right with simultaneous ack
    for (int e = 0; e < 5; e++) begin
      applyStimulus(8'h04, 1'b0);
      checkSlot("switch_left", 1'b1, 8'h04, 1'b0);
    end
    applyStimulus(8'h07, 1'b1);
    checkSlot("switch_ack_emit", 1'b1, 8'h07, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      applyStimulus(8'h07, 1'b1);
      exp_v = (e == 10);
      checkSlot("switch_das", exp_v, exp_v ? 8'h07 : 8'h00, 1'b0);
    end
    applyStimulus(8'h00, 1'b1);

    // Reset while in REPEAT with right still held
    for (int e = 0; e < 11; e++) applyStimulus(8'h07, 1'b1);
    applyStimulus(8'h07, 1'b0);
    checkSlot("pre_reset_pending", 1'b1, 8'h07, 1'b0);
    Reset = 1'b1;
    applyStimulus(8'h07, 1'b0);
    checkSlot("mid_reset", 1'b0, 8'h00, 1'b0);
    Reset = 1'b0;
    applyStimulus(8'h07, 1'b0);
    checkSlot("post_reset_press", 1'b1, 8'h07, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      applyStimulus(8'h07, 1'b1);
      exp_v = (e == 10);
      checkSlot("post_reset_das", exp_v, exp_v ? 8'h07 : 8'h00, 1'b0);
    end
    applyStimulus(8'h00, 1'b1);
    checkSlot("post_reset_release", 1'b0, 8'h00, 1'b0);

    // Unrecognised 0x2C: no emission, and it releases a held key
    for (int e = 0; e < 3; e++) begin
      applyStimulus(8'h2C, 1'b0);
      checkSlot("unknown_key", 1'b0, 8'h00, 1'b0);
    end
    applyStimulus(8'h16, 1'b1);
    checkSlot("down_press", 1'b1, 8'h16, 1'b0);
    applyStimulus(8'h2C, 1'b1);
    checkSlot("unknown_releases", 1'b0, 8'h00, 1'b0);
    applyStimulus(8'h16, 1'b1);
    checkSlot("down_repress", 1'b1, 8'h16, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
